// File: rtl/bram_tdp_init_if.sv
// bram_tdp_init_if: port bundle for the dual-port init RAM.
// Master drives requests; slave returns busy and port data.
interface bram_tdp_init_if #(
  parameter int WIDTH = 36,
  parameter int ADDR  = 10
);
  logic             init_req;
  logic             busy;
  logic             rea;
  logic             reb;
  logic             wea;
  logic             web;
  logic             rsta;
  logic             rstb;
  logic [ADDR-1:0]  raddra;
  logic [ADDR-1:0]  raddrb;
  logic [ADDR-1:0]  waddra;
  logic [ADDR-1:0]  waddrb;
  logic [WIDTH-1:0] wia;
  logic [WIDTH-1:0] wib;
  logic [WIDTH-1:0] ria;
  logic [WIDTH-1:0] rib;
  logic [WIDTH-1:0] doa;
  logic [WIDTH-1:0] dob;

  modport master (
    output init_req,
    output rea, reb, wea, web, rsta, rstb,
    output raddra, raddrb, waddra, waddrb,
    output wia, wib, ria, rib,
    input  busy, doa, dob
  );

  modport slave (
    input  init_req,
    input  rea, reb, wea, web, rsta, rstb,
    input  raddra, raddrb, waddra, waddrb,
    input  wia, wib, ria, rib,
    output busy, doa, dob
  );
endinterface

// File: rtl/bram_tdp_init.sv
// bram_tdp_init: true-dual-port RAM filled by a hardware init sweep.
// Define BRAM_OUTREG_EN to add one output register stage on doa/dob.
module bram_tdp_init #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 1024,
  parameter int ADDR  = 10,
  parameter int OFS   = 0,
  parameter int INCR  = 0
) (
  input logic            clk,
  input logic            rst,
  bram_tdp_init_if.slave bus
);
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [ADDR-1:0] LAST = ADDR'(DEPTH - 1);
  localparam bit FULL = (DEPTH == (1 << ADDR));

  logic [WIDTH-1:0] ram [DEPTH];

  state_t           state_q;
  state_t           state_d;
  logic [ADDR-1:0]  cnt_q;
  logic [ADDR-1:0]  cnt_d;
  logic             busy;
  logic [WIDTH-1:0] init_val;

  logic             okra;
  logic             okrb;
  logic             okwa;
  logic             okwb;
  logic             rda;
  logic             rdb;
  logic             wra;
  logic             wrb;
  logic             rsa;
  logic             rsb;
  logic             wa_en;
  logic             wb_en;
  logic             b_wins;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic [WIDTH-1:0] pa_q;
  logic [WIDTH-1:0] pb_q;

  assign init_val = WIDTH'(OFS) + WIDTH'(cnt_q) * WIDTH'(INCR);

  // Sweep state and word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep every word once, then serve ports
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    unique case (state_q)
      INIT: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
        if (bus.init_req) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.busy = busy;

  // Range checks only matter when DEPTH leaves unused addresses
  if (FULL) begin : g_full
    assign okra = 1'b1;
    assign okrb = 1'b1;
    assign okwa = 1'b1;
    assign okwb = 1'b1;
  end else begin : g_part
    assign okra = 32'(bus.raddra) < DEPTH;
    assign okrb = 32'(bus.raddrb) < DEPTH;
    assign okwa = 32'(bus.waddra) < DEPTH;
    assign okwb = 32'(bus.waddrb) < DEPTH;
  end

  // Per-port priority: read, then write, then restore
  assign rda = ~busy & bus.rea;
  assign rdb = ~busy & bus.reb;
  assign wra = ~busy & bus.wea & ~bus.rea;
  assign wrb = ~busy & bus.web & ~bus.reb;
  assign rsa = ~busy & bus.rsta & ~bus.rea & ~bus.wea;
  assign rsb = ~busy & bus.rstb & ~bus.reb & ~bus.web;

  assign wa_en  = wra & okwa;
  assign wb_en  = wrb & okwb;
  assign b_wins = wb_en & ~(wa_en & (bus.waddra == bus.waddrb));

  // Reads see the other port's same-cycle write
  always_comb begin
    rdata_a = '0;
    if (wb_en && bus.waddrb == bus.raddra) begin
      rdata_a = bus.wib;
    end else if (okra) begin
      rdata_a = ram[bus.raddra];
    end
  end

  // Port B mirror of the bypassed read
  always_comb begin
    rdata_b = '0;
    if (wa_en && bus.waddra == bus.raddrb) begin
      rdata_b = bus.wia;
    end else if (okrb) begin
      rdata_b = ram[bus.raddrb];
    end
  end

  // Storage: sweep writes while busy, port writes otherwise
  always_ff @(posedge clk) begin
    if (busy) begin
      ram[cnt_q] <= init_val;
    end else begin
      if (wa_en) begin
        ram[bus.waddra] <= bus.wia;
      end
      if (b_wins) begin
        ram[bus.waddrb] <= bus.wib;
      end
    end
  end

  // Port A data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pa_q <= '0;
    end else begin
      unique case (1'b1)
        rda:     pa_q <= rdata_a;
        wra:     pa_q <= bus.wia;
        rsa:     pa_q <= bus.ria;
        default: pa_q <= pa_q;
      endcase
    end
  end

  // Port B data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pb_q <= '0;
    end else begin
      unique case (1'b1)
        rdb:     pb_q <= rdata_b;
        wrb:     pb_q <= bus.wib;
        rsb:     pb_q <= bus.rib;
        default: pb_q <= pb_q;
      endcase
    end
  end

`ifdef BRAM_OUTREG_EN
  logic [WIDTH-1:0] oa_q;
  logic [WIDTH-1:0] ob_q;

  // Extra output stage for timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oa_q <= '0;
      ob_q <= '0;
    end else begin
      oa_q <= pa_q;
      ob_q <= pb_q;
    end
  end

  assign bus.doa = oa_q;
  assign bus.dob = ob_q;
`else
  assign bus.doa = pa_q;
  assign bus.dob = pb_q;
`endif

endmodule

// File: tb/tb_bram_tdp_init.sv
// tb_bram_tdp_init: randomized bench with a word-level memory model.
// Latency adapts to BRAM_OUTREG_EN.
module tb_bram_tdp_init;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int ADDR  = 4;
  localparam int OFS   = 3;
  localparam int INCR  = 2;
`ifdef BRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  bram_tdp_init_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

  bram_tdp_init #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .ADDR (ADDR),
    .OFS  (OFS),
    .INCR (INCR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [DEPTH];
  logic [7:0] m1a = 8'h00;
  logic [7:0] m1b = 8'h00;
  logic [7:0] m2a = 8'h00;
  logic [7:0] m2b = 8'h00;
  int         left = DEPTH;

  function automatic logic [7:0] ea();
    return (LAT == 2) ? m2a : m1a;
  endfunction

  function automatic logic [7:0] eb();
    return (LAT == 2) ? m2b : m1b;
  endfunction

  task automatic model_init();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 8'(OFS + i * INCR);
    end
    left = DEPTH;
  endtask

  task automatic idle();
    bus.init_req = 1'b0;
    bus.rea      = 1'b0;
    bus.reb      = 1'b0;
    bus.wea      = 1'b0;
    bus.web      = 1'b0;
    bus.rsta     = 1'b0;
    bus.rstb     = 1'b0;
    bus.raddra   = '0;
    bus.raddrb   = '0;
    bus.waddra   = '0;
    bus.waddrb   = '0;
    bus.wia      = '0;
    bus.wib      = '0;
    bus.ria      = '0;
    bus.rib      = '0;
  endtask

  // Advance the model by one clock from the current inputs, then clock the DUT.
  task automatic step();
    logic [7:0] na;
    logic [7:0] nb;
    na = m1a;
    nb = m1b;
    if (left > 0) begin
      left--;
    end else begin
      if (bus.rea) begin
        if (bus.web && !bus.reb && bus.waddrb == bus.raddra) na = bus.wib;
        else na = mem[bus.raddra];
      end else if (bus.wea) begin
        na = bus.wia;
      end else if (bus.rsta) begin
        na = bus.ria;
      end
      if (bus.reb) begin
        if (bus.wea && !bus.rea && bus.waddra == bus.raddrb) nb = bus.wia;
        else nb = mem[bus.raddrb];
      end else if (bus.web) begin
        nb = bus.wib;
      end else if (bus.rstb) begin
        nb = bus.rib;
      end
      if (bus.web && !bus.reb) mem[bus.waddrb] = bus.wib;
      if (bus.wea && !bus.rea) mem[bus.waddra] = bus.wia;
      if (bus.init_req) model_init();
    end
    m2a = m1a;
    m2b = m1b;
    m1a = na;
    m1b = nb;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    idle();
    for (int i = 1; i < LAT; i++) step();
  endtask

  task automatic test_reset();
    int n;
    logic [7:0] stuck;
    idle();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_busy got %b want 1", bus.busy);
    end
    n_cmp++;
    if (bus.doa !== 8'h00 || bus.dob !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_do got %h/%h want 00/00", bus.doa, bus.dob);
    end
    rst = 1'b0;
    model_init();
    n = 0;
    stuck = 8'h00;
    bus.rea = 1'b1;
    while (bus.busy === 1'b1 && n < 40) begin
      bus.raddra = 4'($urandom);
      step();
      stuck = stuck | bus.doa;
      n++;
    end
    n_cmp++;
    if (n != DEPTH) begin
      n_bad++;
      $display("FAIL rst_sweep_len got %0d want %0d", n, DEPTH);
    end
    n_cmp++;
    if (stuck !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_busy_ignore got %h want 00", stuck);
    end
    idle();
  endtask

  task automatic test_init_values();
    for (int i = 0; i < DEPTH; i++) begin
      bus.rea    = 1'b1;
      bus.reb    = 1'b1;
      bus.raddra = 4'(i);
      bus.raddrb = 4'(DEPTH - 1 - i);
      step();
      n_cmp++;
      if (bus.doa !== ea() || bus.dob !== eb()) begin
        n_bad++;
        $display("FAIL init_rd[%0d] got %h/%h want %h/%h",
                 i, bus.doa, bus.dob, ea(), eb());
      end
    end
    idle();
    bus.rea    = 1'b1;
    bus.raddra = 4'd5;
    bus.reb    = 1'b1;
    bus.raddrb = 4'd15;
    step();
    settle();
    n_cmp++;
    if (bus.doa !== 8'd13) begin
      n_bad++;
      $display("FAIL init_rd5 got %0d want 13", bus.doa);
    end
    n_cmp++;
    if (bus.dob !== 8'd33) begin
      n_bad++;
      $display("FAIL init_rd15 got %0d want 33", bus.dob);
    end
  endtask

  task automatic test_collision();
    idle();
    bus.wea    = 1'b1;
    bus.waddra = 4'd7;
    bus.wia    = 8'hAA;
    bus.web    = 1'b1;
    bus.waddrb = 4'd7;
    bus.wib    = 8'h55;
    step();
    settle();
    n_cmp++;
    if (bus.doa !== 8'hAA || bus.dob !== 8'h55) begin
      n_bad++;
      $display("FAIL ww_out got %h/%h want aa/55", bus.doa, bus.dob);
    end
    bus.reb    = 1'b1;
    bus.raddrb = 4'd7;
    step();
    settle();
    n_cmp++;
    if (bus.dob !== 8'hAA) begin
      n_bad++;
      $display("FAIL ww_store got %h want aa", bus.dob);
    end
  endtask

  task automatic test_bypass();
    idle();
    bus.wea    = 1'b1;
    bus.waddra = 4'd4;
    bus.wia    = 8'h11;
    bus.reb    = 1'b1;
    bus.raddrb = 4'd4;
    step();
    settle();
    n_cmp++;
    if (bus.dob !== 8'h11) begin
      n_bad++;
      $display("FAIL bypass got %h want 11", bus.dob);
    end
    bus.rea    = 1'b1;
    bus.raddra = 4'd4;
    bus.wea    = 1'b1;
    bus.waddra = 4'd4;
    bus.wia    = 8'h99;
    step();
    settle();
    n_cmp++;
    if (bus.doa !== 8'h11) begin
      n_bad++;
      $display("FAIL rw_same got %h want 11", bus.doa);
    end
    bus.reb    = 1'b1;
    bus.raddrb = 4'd4;
    step();
    settle();
    n_cmp++;
    if (bus.dob !== 8'h11) begin
      n_bad++;
      $display("FAIL rw_drop got %h want 11", bus.dob);
    end
  endtask

  task automatic test_restore();
    idle();
    bus.rsta = 1'b1;
    bus.ria  = 8'h5A;
    bus.rstb = 1'b1;
    bus.rib  = 8'hA5;
    step();
    idle();
    if (LAT == 2) begin
      n_cmp++;
      if (bus.doa === 8'h5A) begin
        n_bad++;
        $display("FAIL restore_early got %h want not 5a", bus.doa);
      end
    end
    settle();
    n_cmp++;
    if (bus.doa !== 8'h5A || bus.dob !== 8'hA5) begin
      n_bad++;
      $display("FAIL restore got %h/%h want 5a/a5", bus.doa, bus.dob);
    end
  endtask

  task automatic test_init_req();
    int n;
    idle();
    bus.wea    = 1'b1;
    bus.waddra = 4'd2;
    bus.wia    = 8'hFF;
    step();
    bus.wea    = 1'b0;
    bus.rea    = 1'b1;
    bus.raddra = 4'd2;
    step();
    settle();
    n_cmp++;
    if (bus.doa !== 8'hFF) begin
      n_bad++;
      $display("FAIL ireq_pre got %h want ff", bus.doa);
    end
    bus.init_req = 1'b1;
    step();
    idle();
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      step();
      n++;
    end
    n_cmp++;
    if (n != DEPTH) begin
      n_bad++;
      $display("FAIL ireq_len got %0d want %0d", n, DEPTH);
    end
    bus.rea    = 1'b1;
    bus.raddra = 4'd2;
    step();
    settle();
    n_cmp++;
    if (bus.doa !== 8'd7) begin
      n_bad++;
      $display("FAIL ireq_rd2 got %0d want 7", bus.doa);
    end
  endtask

  task automatic test_rst_mid_sweep();
    int n;
    logic [7:0] stuck;
    idle();
    bus.init_req = 1'b1;
    step();
    idle();
    repeat (8) step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.doa !== 8'h00 || bus.dob !== 8'h00) begin
      n_bad++;
      $display("FAIL mid_rst_do got %h/%h want 00/00", bus.doa, bus.dob);
    end
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_rst_busy got %b want 1", bus.busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m1a = 8'h00;
    m1b = 8'h00;
    m2a = 8'h00;
    m2b = 8'h00;
    model_init();
    n = 0;
    stuck = 8'h00;
    bus.rea = 1'b1;
    while (bus.busy === 1'b1 && n < 40) begin
      bus.raddra = 4'($urandom);
      step();
      stuck = stuck | bus.doa;
      n++;
    end
    n_cmp++;
    if (n != DEPTH) begin
      n_bad++;
      $display("FAIL mid_sweep_len got %0d want %0d", n, DEPTH);
    end
    n_cmp++;
    if (stuck !== 8'h00) begin
      n_bad++;
      $display("FAIL mid_busy_ignore got %h want 00", stuck);
    end
    bus.raddra = 4'd5;
    step();
    settle();
    n_cmp++;
    if (bus.doa !== 8'd13) begin
      n_bad++;
      $display("FAIL mid_rd5 got %0d want 13", bus.doa);
    end
  endtask

  task automatic test_random();
    bit narrow;
    for (int i = 0; i < 400; i++) begin
      narrow       = ($urandom_range(0, 1) == 0);
      bus.rea      = ($urandom_range(0, 2) == 0);
      bus.reb      = ($urandom_range(0, 2) == 0);
      bus.wea      = ($urandom_range(0, 1) == 0);
      bus.web      = ($urandom_range(0, 1) == 0);
      bus.rsta     = ($urandom_range(0, 2) == 0);
      bus.rstb     = ($urandom_range(0, 2) == 0);
      bus.init_req = ($urandom_range(0, 79) == 0);
      bus.raddra   = 4'($urandom_range(0, narrow ? 3 : 15));
      bus.raddrb   = 4'($urandom_range(0, narrow ? 3 : 15));
      bus.waddra   = 4'($urandom_range(0, narrow ? 3 : 15));
      bus.waddrb   = 4'($urandom_range(0, narrow ? 3 : 15));
      bus.wia      = 8'($urandom);
      bus.wib      = 8'($urandom);
      bus.ria      = 8'($urandom);
      bus.rib      = 8'($urandom);
      step();
      n_cmp++;
      if (bus.doa !== ea() || bus.dob !== eb()) begin
        n_bad++;
        $display("FAIL rand_do[%0d] got %h/%h want %h/%h",
                 i, bus.doa, bus.dob, ea(), eb());
      end
      n_cmp++;
      if (bus.busy !== (left > 0)) begin
        n_bad++;
        $display("FAIL rand_busy[%0d] got %b want %b",
                 i, bus.busy, (left > 0));
      end
    end
    idle();
    while (left > 0) step();
  endtask

  initial begin
    idle();
    test_reset();
    test_init_values();
    test_collision();
    test_bypass();
    test_restore();
    test_init_req();
    test_rst_mid_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
